// File: rtl/trace_frame_rx_if.sv
//------------------------------------------------------------------------------
// Module  : trace_frame_rx_if
// Brief   : Byte-level link between trace_frame_rx and a uart_tx/uart_rx pair.
// Rev     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface trace_frame_rx_if;
    logic       tx_dv;
    logic [7:0] tx_byte;
    logic       tx_done;
    logic       rx_dv;
    logic [7:0] rx_byte;

    // master = frame receiver, slave = UART side
    modport master (
        output tx_dv,
        output tx_byte,
        input  tx_done,
        input  rx_dv,
        input  rx_byte
    );

    modport slave (
        input  tx_dv,
        input  tx_byte,
        output tx_done,
        output rx_dv,
        output rx_byte
    );
endinterface

`default_nettype wire

// File: rtl/trace_frame_rx.sv
//------------------------------------------------------------------------------
// Module  : trace_frame_rx
// Brief   : Sends one command byte, then captures PT/KEY/CT/trace frame fields
//           with AES-done marker statistics and inter-byte timeout detection.
// Rev     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module trace_frame_rx #(
    parameter int HDR_BYTES   = 16,
    parameter int TRACE_LEN   = 2048,
    parameter int ADDR_W      = 11,
    parameter int TIMEOUT_CYC = 1000000,
    parameter int MARKER      = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [7:0]        cmd_byte_i,
    input  logic [1:0]        rd_sel_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [7:0]        rd_data_o,
    output logic              busy_o,
    output logic              frame_done_o,
    output logic              timeout_err_o,
    output logic [11:0]       marker_cnt_o,
    output logic [ADDR_W-1:0] first_marker_o,
    output logic              marker_seen_o,
    output logic [7:0]        stray_cnt_o,
    trace_frame_rx_if.master  uart
);

    localparam int c_HW = (HDR_BYTES > 1) ? $clog2(HDR_BYTES) : 1;
    localparam int c_TW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [ADDR_W-1:0] c_HDR_LAST   = ADDR_W'(HDR_BYTES - 1);
    localparam logic [ADDR_W-1:0] c_TRACE_LAST = ADDR_W'(TRACE_LEN - 1);
    localparam logic [c_TW-1:0]   c_TIMER_LAST = c_TW'(TIMEOUT_CYC - 1);
    localparam logic [7:0]        c_MARKER     = 8'(MARKER);
    localparam logic [11:0]       c_CNT_MAX    = 12'hFFF;
    localparam logic [7:0]        c_STRAY_MAX  = 8'hFF;

    localparam logic [3:0] c_IDLE     = 4'd0;
    localparam logic [3:0] c_SEND     = 4'd1;
    localparam logic [3:0] c_WAIT_TX  = 4'd2;
    localparam logic [3:0] c_RX_PT    = 4'd3;
    localparam logic [3:0] c_RX_KEY   = 4'd4;
    localparam logic [3:0] c_RX_CT    = 4'd5;
    localparam logic [3:0] c_RX_TRACE = 4'd6;
    localparam logic [3:0] c_DONE     = 4'd7;
    localparam logic [3:0] c_ERR      = 4'd8;

    logic [3:0]        state_q;
    logic [3:0]        state_d;
    logic [ADDR_W-1:0] idx_q;
    logic [c_TW-1:0]   timer_q;
    logic [7:0]        tx_byte_q;
    logic              tx_dv_q;
    logic              tx_dv_d;
    logic              busy_q;
    logic              timeout_err_q;
    logic [11:0]       marker_cnt_q;
    logic [ADDR_W-1:0] first_marker_q;
    logic              marker_seen_q;
    logic [7:0]        stray_cnt_q;
    logic [7:0]        rd_data_q;

    logic [7:0] pt_mem_q    [HDR_BYTES];
    logic [7:0] key_mem_q   [HDR_BYTES];
    logic [7:0] ct_mem_q    [HDR_BYTES];
    logic [7:0] trace_mem_q [TRACE_LEN];

    logic       w_accept;
    logic       w_hdr_state;
    logic       w_rx_state;
    logic       w_wait_state;
    logic       w_evt;
    logic       w_timeout;
    logic       w_last_hdr;
    logic       w_last_trace;
    logic       w_store;
    logic       w_is_marker;
    logic [7:0] w_rd_data;

    assign w_accept     = (state_q == c_IDLE) && start_i;
    assign w_hdr_state  = (state_q == c_RX_PT) || (state_q == c_RX_KEY) || (state_q == c_RX_CT);
    assign w_rx_state   = w_hdr_state || (state_q == c_RX_TRACE);
    assign w_wait_state = w_rx_state || (state_q == c_WAIT_TX);
    assign w_evt        = (state_q == c_WAIT_TX) ? uart.tx_done : uart.rx_dv;
    assign w_timeout    = (timer_q == c_TIMER_LAST);
    assign w_last_hdr   = (idx_q == c_HDR_LAST);
    assign w_last_trace = (idx_q == c_TRACE_LAST);
    assign w_store      = w_rx_state && uart.rx_dv;
    assign w_is_marker  = (state_q == c_RX_TRACE) && uart.rx_dv && (uart.rx_byte == c_MARKER);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= c_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A received event always beats a timeout landing in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE:     if (start_i) state_d = c_SEND;
            c_SEND:     state_d = c_WAIT_TX;
            c_WAIT_TX: begin
                if (uart.tx_done)  state_d = c_RX_PT;
                else if (w_timeout) state_d = c_ERR;
            end
            c_RX_PT: begin
                if (uart.rx_dv) begin
                    if (w_last_hdr) state_d = c_RX_KEY;
                end else if (w_timeout) begin
                    state_d = c_ERR;
                end
            end
            c_RX_KEY: begin
                if (uart.rx_dv) begin
                    if (w_last_hdr) state_d = c_RX_CT;
                end else if (w_timeout) begin
                    state_d = c_ERR;
                end
            end
            c_RX_CT: begin
                if (uart.rx_dv) begin
                    if (w_last_hdr) state_d = c_RX_TRACE;
                end else if (w_timeout) begin
                    state_d = c_ERR;
                end
            end
            c_RX_TRACE: begin
                if (uart.rx_dv) begin
                    if (w_last_trace) state_d = c_DONE;
                end else if (w_timeout) begin
                    state_d = c_ERR;
                end
            end
            c_DONE:  state_d = c_IDLE;
            c_ERR:   state_d = c_IDLE;
            default: state_d = c_IDLE;
        endcase
    end

    always_comb begin
        tx_dv_d      = (state_q == c_SEND);
        frame_done_o = (state_q == c_DONE);
    end

    always_comb begin
        w_rd_data = '0;
        case (rd_sel_i)
            2'd0:    w_rd_data = pt_mem_q[rd_addr_i[c_HW-1:0]];
            2'd1:    w_rd_data = key_mem_q[rd_addr_i[c_HW-1:0]];
            2'd2:    w_rd_data = ct_mem_q[rd_addr_i[c_HW-1:0]];
            default: w_rd_data = trace_mem_q[rd_addr_i];
        endcase
    end

    // Buffers carry no reset; their contents survive aborts and resets.
    always_ff @(posedge clk) begin
        if (uart.rx_dv) begin
            case (state_q)
                c_RX_PT:    pt_mem_q[idx_q[c_HW-1:0]]  <= uart.rx_byte;
                c_RX_KEY:   key_mem_q[idx_q[c_HW-1:0]] <= uart.rx_byte;
                c_RX_CT:    ct_mem_q[idx_q[c_HW-1:0]]  <= uart.rx_byte;
                c_RX_TRACE: trace_mem_q[idx_q]         <= uart.rx_byte;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q          <= '0;
            timer_q        <= '0;
            tx_byte_q      <= '0;
            tx_dv_q        <= 1'b0;
            busy_q         <= 1'b0;
            timeout_err_q  <= 1'b0;
            marker_cnt_q   <= '0;
            first_marker_q <= '0;
            marker_seen_q  <= 1'b0;
            stray_cnt_q    <= '0;
            rd_data_q      <= '0;
        end else begin
            tx_dv_q   <= tx_dv_d;
            rd_data_q <= w_rd_data;

            if (w_accept) begin
                tx_byte_q      <= cmd_byte_i;
                busy_q         <= 1'b1;
                timeout_err_q  <= 1'b0;
                marker_cnt_q   <= '0;
                first_marker_q <= '0;
                marker_seen_q  <= 1'b0;
            end

            // Flags update on the edge that enters DONE/ERR, so the abort
            // lands exactly TIMEOUT_CYC edges after the last event.
            if ((state_d == c_DONE) || (state_d == c_ERR)) begin
                busy_q <= 1'b0;
            end
            if (state_d == c_ERR) begin
                timeout_err_q <= 1'b1;
            end

            if (w_accept) begin
                idx_q <= '0;
            end else if (w_store) begin
                if (w_hdr_state) begin
                    idx_q <= w_last_hdr ? '0 : idx_q + 1'b1;
                end else begin
                    idx_q <= w_last_trace ? '0 : idx_q + 1'b1;
                end
            end

            if (w_wait_state && !w_evt) begin
                timer_q <= timer_q + 1'b1;
            end else begin
                timer_q <= '0;
            end

            if (w_is_marker) begin
                if (marker_cnt_q != c_CNT_MAX) begin
                    marker_cnt_q <= marker_cnt_q + 1'b1;
                end
                if (!marker_seen_q) begin
                    first_marker_q <= idx_q;
                    marker_seen_q  <= 1'b1;
                end
            end

            if (uart.rx_dv && !w_rx_state && (stray_cnt_q != c_STRAY_MAX)) begin
                stray_cnt_q <= stray_cnt_q + 1'b1;
            end
        end
    end

    assign uart.tx_dv     = tx_dv_q;
    assign uart.tx_byte   = tx_byte_q;
    assign rd_data_o      = rd_data_q;
    assign busy_o         = busy_q;
    assign timeout_err_o  = timeout_err_q;
    assign marker_cnt_o   = marker_cnt_q;
    assign first_marker_o = first_marker_q;
    assign marker_seen_o  = marker_seen_q;
    assign stray_cnt_o    = stray_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_trace_frame_rx.sv
//------------------------------------------------------------------------------
// Module  : tb_trace_frame_rx
// Brief   : Directed self-checking bench for trace_frame_rx (TIMEOUT_CYC = 50).
// Rev     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_trace_frame_rx;

    localparam int ADDR_W = 11;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [7:0]        cmd_byte;
    logic [1:0]        rd_sel;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic              busy;
    logic              frame_done;
    logic              timeout_err;
    logic [11:0]       marker_cnt;
    logic [ADDR_W-1:0] first_marker;
    logic              marker_seen;
    logic [7:0]        stray_cnt;

    int checks = 0;
    int errors = 0;
    int fd_count = 0;
    int fd_base;

    trace_frame_rx_if u_if ();

    trace_frame_rx #(
        .HDR_BYTES   (16),
        .TRACE_LEN   (2048),
        .ADDR_W      (ADDR_W),
        .TIMEOUT_CYC (50),
        .MARKER      (255)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start),
        .cmd_byte_i     (cmd_byte),
        .rd_sel_i       (rd_sel),
        .rd_addr_i      (rd_addr),
        .rd_data_o      (rd_data),
        .busy_o         (busy),
        .frame_done_o   (frame_done),
        .timeout_err_o  (timeout_err),
        .marker_cnt_o   (marker_cnt),
        .first_marker_o (first_marker),
        .marker_seen_o  (marker_seen),
        .stray_cnt_o    (stray_cnt),
        .uart           (u_if)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done) fd_count++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Normal traces carry idx[7:0]; natural 0xFF values are moved to 0xFE so
    // only the planted markers count.
    function automatic logic [7:0] tval(input int kind, input int i);
        logic [7:0] b;
        if (kind == 1) return 8'hFF;
        if (i == 100 || i == 300) return 8'hFF;
        b = i[7:0];
        if (b == 8'hFF) return 8'hFE;
        return b;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        u_if.rx_dv   = 1'b1;
        u_if.rx_byte = b;
        tick();
        u_if.rx_dv   = 1'b0;
    endtask

    task automatic do_start(input logic [7:0] cmd);
        start    = 1'b1;
        cmd_byte = cmd;
        tick();
        start = 1'b0;
        chk("start_busy", busy, 1'b1);
        chk("start_clr_err", timeout_err, 1'b0);
        chk("tx_dv_early", u_if.tx_dv, 1'b0);
        tick();
        chk("tx_dv_pulse", u_if.tx_dv, 1'b1);
        chk("tx_byte", u_if.tx_byte, cmd);
    endtask

    task automatic finish_tx();
        tick();
        chk("tx_dv_single", u_if.tx_dv, 1'b0);
        u_if.tx_done = 1'b1;
        tick();
        u_if.tx_done = 1'b0;
    endtask

    task automatic send_hdr(input logic [7:0] base, input bit inject_start);
        for (int i = 0; i < 48; i++) begin
            if (inject_start && i == 21) begin
                start    = 1'b1;
                cmd_byte = 8'd99;
                tick();
                start = 1'b0;
                chk("ign_start_busy", busy, 1'b1);
                tick();
                chk("ign_start_txdv", u_if.tx_dv, 1'b0);
                tick();
                chk("ign_start_txdv2", u_if.tx_dv, 1'b0);
                chk("ign_start_txbyte", u_if.tx_byte, 8'd7);
            end
            send_byte(base + 8'(i));
        end
    endtask

    task automatic send_trace(input int kind, input int n);
        for (int i = 0; i < n; i++) send_byte(tval(kind, i));
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] sel, input int addr,
                          input logic [7:0] exp);
        rd_sel  = sel;
        rd_addr = ADDR_W'(addr);
        tick();
        chk(tag, rd_data, exp);
    endtask

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        cmd_byte     = 8'd0;
        rd_sel       = 2'd0;
        rd_addr      = '0;
        u_if.tx_done = 1'b0;
        u_if.rx_dv   = 1'b0;
        u_if.rx_byte = 8'd0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        chk("rst_busy", busy, 1'b0);
        chk("rst_tx_dv", u_if.tx_dv, 1'b0);
        chk("rst_tx_byte", u_if.tx_byte, 8'd0);
        chk("rst_frame_done", frame_done, 1'b0);
        chk("rst_timeout", timeout_err, 1'b0);
        chk("rst_marker_cnt", marker_cnt, 12'd0);
        chk("rst_marker_seen", marker_seen, 1'b0);
        chk("rst_stray", stray_cnt, 8'd0);

        // Bytes arriving while idle are counted, not stored.
        repeat (3) send_byte(8'hA5);
        chk("stray_cnt3", stray_cnt, 8'd3);
        chk("stray_busy", busy, 1'b0);

        // Normal frame with command 250.
        fd_base = fd_count;
        do_start(8'd250);
        finish_tx();
        send_hdr(8'h00, 1'b0);
        send_trace(0, 2048);
        chk("f1_frame_done", frame_done, 1'b1);
        chk("f1_busy_low", busy, 1'b0);
        tick();
        chk("f1_frame_done_drop", frame_done, 1'b0);
        chk("f1_fd_once", fd_count - fd_base, 1);
        chk("f1_marker_cnt", marker_cnt, 12'd2);
        chk("f1_first_marker", first_marker, 11'd100);
        chk("f1_marker_seen", marker_seen, 1'b1);
        chk("f1_stray_kept", stray_cnt, 8'd3);
        rd_chk("f1_pt5", 2'd0, 5, 8'h05);
        rd_chk("f1_key15", 2'd1, 15, 8'h1F);
        rd_chk("f1_ct0", 2'd2, 0, 8'h20);
        rd_chk("f1_tr7", 2'd3, 7, 8'h07);
        rd_chk("f1_tr300", 2'd3, 300, 8'hFF);

        // Timeout mid-trace; byte 59 arrives on the would-be timeout cycle.
        fd_base = fd_count;
        do_start(8'd5);
        finish_tx();
        send_hdr(8'h40, 1'b0);
        send_trace(0, 59);
        repeat (49) tick();
        send_byte(8'd59);
        chk("race_byte_wins_err", timeout_err, 1'b0);
        chk("race_byte_wins_busy", busy, 1'b1);
        repeat (49) tick();
        chk("to_not_yet", timeout_err, 1'b0);
        chk("to_busy_before", busy, 1'b1);
        tick();
        chk("to_err_at_50", timeout_err, 1'b1);
        chk("to_busy_low", busy, 1'b0);
        tick();
        chk("to_no_frame_done", fd_count - fd_base, 0);
        rd_chk("to_pt3", 2'd0, 3, 8'h43);
        rd_chk("to_tr59", 2'd3, 59, 8'd59);

        // Next start clears the error; tx_done then never arrives.
        do_start(8'd12);
        repeat (49) tick();
        chk("txto_not_yet", timeout_err, 1'b0);
        tick();
        chk("txto_err", timeout_err, 1'b1);
        chk("txto_busy_low", busy, 1'b0);
        rd_chk("txto_pt_kept", 2'd0, 3, 8'h43);

        // Ignored start during RX_KEY, then an all-marker trace.
        fd_base = fd_count;
        do_start(8'd7);
        finish_tx();
        send_hdr(8'h80, 1'b1);
        send_trace(1, 2048);
        chk("am_frame_done", frame_done, 1'b1);
        tick();
        chk("am_fd_once", fd_count - fd_base, 1);
        chk("am_marker_cnt", marker_cnt, 12'd2048);
        chk("am_first_marker", first_marker, 11'd0);
        chk("am_marker_seen", marker_seen, 1'b1);
        rd_chk("am_key15", 2'd1, 15, 8'h9F);
        rd_chk("am_tr2047", 2'd3, 2047, 8'hFF);

        // Asynchronous reset at trace byte 1000, then a clean frame.
        fd_base = fd_count;
        do_start(8'd250);
        finish_tx();
        send_hdr(8'h00, 1'b0);
        send_trace(0, 1000);
        chk("pre_rst_marker_cnt", marker_cnt, 12'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_marker_cnt", marker_cnt, 12'd0);
        chk("arst_stray", stray_cnt, 8'd0);
        chk("arst_frame_done", frame_done, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        chk("arst_no_fd", fd_count - fd_base, 0);
        do_start(8'd3);
        finish_tx();
        send_hdr(8'h00, 1'b0);
        send_trace(0, 2048);
        chk("f2_frame_done", frame_done, 1'b1);
        tick();
        chk("f2_fd_once", fd_count - fd_base, 1);
        chk("f2_marker_cnt", marker_cnt, 12'd2);
        chk("f2_first_marker", first_marker, 11'd100);
        chk("f2_stray", stray_cnt, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
